// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a ROWS x COLS matrix keypad. One column is driven at a time. The row
// lines are sensed through a two-flop synchroniser. Presses and releases are
// debounced, and a held key can optionally produce typematic auto-repeat
// events. Key codes are delivered through a one-entry valid/ready holding
// register. All scan and debounce timing advances only on i_tick, which is a
// one-clock enable from an external divider.
//
// Ports
//   i_clk           system clock
//   i_rst_n         asynchronous, active-low reset
//   i_tick          scan/debounce enable, one clock wide
//   i_rows_in       raw row sense lines, active-high, asynchronous
//   i_repeat_en     enables auto-repeat events
//   i_key_ready     consumer accepts o_key_code this cycle
//   i_clr_overflow  clears the sticky overflow flag
//   o_col_drive     one-hot column drive
//   o_key_valid     o_key_code holds an unconsumed event
//   o_key_code      row*COLS + col of the event
//   o_key_repeat    the held event is an auto-repeat
//   o_key_down      a confirmed key is currently held
//   o_multi_key     one-clock pulse: more than one row seen in the scanned column
//   o_overflow      sticky: an event was dropped because the holder was full
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_DELAY   = 32,
    parameter int REPEAT_RATE    = 8,
    localparam int CW            = $clog2(ROWS * COLS)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_tick,
    input  logic [ROWS-1:0] i_rows_in,
    input  logic            i_repeat_en,
    input  logic            i_key_ready,
    input  logic            i_clr_overflow,
    output logic [COLS-1:0] o_col_drive,
    output logic            o_key_valid,
    output logic [CW-1:0]   o_key_code,
    output logic            o_key_repeat,
    output logic            o_key_down,
    output logic            o_multi_key,
    output logic            o_overflow
);

    localparam int RW      = $clog2(ROWS);
    localparam int CIW     = $clog2(COLS);
    localparam int DBW     = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPW     = $clog2(RPT_MAX + 1);

    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,
        ST_DEBOUNCE   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [ROWS-1:0] r_sync1;
    logic [ROWS-1:0] r_rows_s;
    state_t          r_state;
    logic [CIW-1:0]  r_col_idx;
    logic [RW-1:0]   r_row_idx;
    logic [DBW-1:0]  r_db_cnt;
    logic [RPW-1:0]  r_rpt_cnt;
    logic            r_first_done;
    logic            r_key_down;
    logic            r_multi_key;
    logic            r_key_valid;
    logic [CW-1:0]   r_key_code;
    logic            r_key_repeat;
    logic            r_overflow;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic            w_rows_none;
    logic            w_rows_one;
    logic            w_rows_multi;
    logic [RW-1:0]   w_row_enc;
    logic [ROWS-1:0] w_cap_onehot;
    logic            w_row_match;
    logic            w_row_bit;
    logic [CIW-1:0]  w_col_next;
    logic            w_db_last;
    logic [31:0]     w_rpt_limit;
    logic            w_rpt_last;
    logic            w_press_evt;
    logic            w_rpt_evt;
    logic            w_event;
    logic [CW-1:0]   w_event_code;

    // A vector with exactly one bit set becomes zero once its lowest set bit
    // is cleared, so "one row" and "many rows" need no popcount.
    assign w_rows_none  = (r_rows_s == '0);
    assign w_rows_one   = !w_rows_none && ((r_rows_s & (r_rows_s - ROWS'(1))) == '0);
    assign w_rows_multi = !w_rows_none && !w_rows_one;

    // Row encoder; only consulted when exactly one row is active.
    always_comb begin
        w_row_enc = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (r_rows_s[i]) begin
                w_row_enc = RW'(i);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_cap_onehot
            assign w_cap_onehot[gi] = (r_row_idx == RW'(gi));
        end
        for (gi = 0; gi < COLS; gi++) begin : g_col_drive
            assign o_col_drive[gi] = (r_col_idx == CIW'(gi));
        end
    endgenerate

    // Debounce of a press needs the whole row vector to match the captured
    // key; the held/released test only looks at the captured row line.
    assign w_row_match = (r_rows_s == w_cap_onehot);
    assign w_row_bit   = |(r_rows_s & w_cap_onehot);

    assign w_col_next  = (r_col_idx == CIW'(COLS - 1)) ? '0 : (r_col_idx + CIW'(1));

    assign w_db_last   = ((32'(r_db_cnt) + 32'd1) == 32'(DEBOUNCE_TICKS));
    assign w_rpt_limit = r_first_done ? 32'(REPEAT_RATE) : 32'(REPEAT_DELAY);
    assign w_rpt_last  = ((32'(r_rpt_cnt) + 32'd1) == w_rpt_limit);

    assign w_press_evt = i_tick && (r_state == ST_DEBOUNCE) && w_row_match && w_db_last;
    assign w_rpt_evt   = i_tick && (r_state == ST_PRESSED) && w_row_bit &&
                         i_repeat_en && w_rpt_last;
    assign w_event     = w_press_evt || w_rpt_evt;

    // Largest code is ROWS*COLS-1, which always fits in CW bits.
    assign w_event_code = CW'(r_row_idx) * CW'(COLS) + CW'(r_col_idx);

    // -------------------------------------------------------------------------
    // Row synchroniser (runs every clock, independent of i_tick)
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= '0;
            r_rows_s <= '0;
        end else begin
            r_sync1  <= i_rows_in;
            r_rows_s <= r_sync1;
        end
    end

    // -------------------------------------------------------------------------
    // Scan / debounce / repeat FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_SCAN;
            r_col_idx    <= '0;
            r_row_idx    <= '0;
            r_db_cnt     <= '0;
            r_rpt_cnt    <= '0;
            r_first_done <= 1'b0;
            r_key_down   <= 1'b0;
            r_multi_key  <= 1'b0;
        end else begin
            r_multi_key <= 1'b0;
            if (i_tick) begin
                case (r_state)
                    ST_SCAN: begin
                        if (w_rows_one) begin
                            // Column stays frozen while the key is examined.
                            r_row_idx <= w_row_enc;
                            r_db_cnt  <= '0;
                            r_state   <= ST_DEBOUNCE;
                        end else begin
                            r_col_idx <= w_col_next;
                            if (w_rows_multi) begin
                                r_multi_key <= 1'b1;
                            end
                        end
                    end

                    ST_DEBOUNCE: begin
                        if (w_row_match) begin
                            if (w_db_last) begin
                                r_state      <= ST_PRESSED;
                                r_key_down   <= 1'b1;
                                r_rpt_cnt    <= '0;
                                r_first_done <= 1'b0;
                            end else begin
                                r_db_cnt <= r_db_cnt + DBW'(1);
                            end
                        end else begin
                            r_state   <= ST_SCAN;
                            r_col_idx <= w_col_next;
                        end
                    end

                    ST_PRESSED: begin
                        if (!w_row_bit) begin
                            r_state  <= ST_RELEASE_DB;
                            r_db_cnt <= '0;
                        end else if (i_repeat_en) begin
                            if (w_rpt_last) begin
                                r_rpt_cnt    <= '0;
                                r_first_done <= 1'b1;
                            end else begin
                                r_rpt_cnt <= r_rpt_cnt + RPW'(1);
                            end
                        end else begin
                            r_rpt_cnt    <= '0;
                            r_first_done <= 1'b0;
                        end
                    end

                    ST_RELEASE_DB: begin
                        if (!w_row_bit) begin
                            if (w_db_last) begin
                                r_state    <= ST_SCAN;
                                r_key_down <= 1'b0;
                                r_col_idx  <= w_col_next;
                            end else begin
                                r_db_cnt <= r_db_cnt + DBW'(1);
                            end
                        end else begin
                            // Bounce during release: resume holding with the
                            // repeat schedule intact.
                            r_state <= ST_PRESSED;
                        end
                    end

                    default: begin
                        r_state    <= ST_SCAN;
                        r_key_down <= 1'b0;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // One-entry holding register with valid/ready handshake
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_key_valid  <= 1'b0;
            r_key_code   <= '0;
            r_key_repeat <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_event) begin
                // A consume in the same cycle frees the slot for the new event.
                if (!r_key_valid || i_key_ready) begin
                    r_key_valid  <= 1'b1;
                    r_key_code   <= w_event_code;
                    r_key_repeat <= w_rpt_evt;
                end
            end else if (r_key_valid && i_key_ready) begin
                r_key_valid <= 1'b0;
            end

            // Later assignment wins: a drop in the clearing cycle keeps the flag.
            if (i_clr_overflow) begin
                r_overflow <= 1'b0;
            end
            if (w_event && r_key_valid && !i_key_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_key_valid  = r_key_valid;
    assign o_key_code   = r_key_code;
    assign o_key_repeat = r_key_repeat;
    assign o_key_down   = r_key_down;
    assign o_multi_key  = r_multi_key;
    assign o_overflow   = r_overflow;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Parametrised matrix-keypad scanner that generalises the row/column lock FSM to an ROWS x COLS matrix.
- Actively drives one column at a time and senses rows through an internal synchroniser.
- Debounces press and release, with optional typematic auto-repeat.
- Delivers key codes through a one-entry valid/ready holding register to the downstream display/input logic.
- Scan and debounce timing run on an external tick enable from the clock divider.

Parameters:
ROWS, 4, number of sensed row lines (>=2)
COLS, 4, number of driven column lines (>=2)
DEBOUNCE_TICKS, 4, consecutive stable ticks required to confirm a press or release (>=1)
REPEAT_DELAY, 32, ticks held before the first auto-repeat (>=1)
REPEAT_RATE, 8, ticks between subsequent auto-repeats (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  scan/debounce enable, one clk wide
rows_in  in  ROWS  raw row sense lines, active-high, asynchronous
repeat_en  in  1  enables auto-repeat events
key_ready  in  1  consumer accepts key_code this cycle
clr_overflow  in  1  clears the overflow flag
col_drive  out  COLS  one-hot column drive
key_valid  out  1  key_code holds an unconsumed event
key_code  out  CW = $clog2(ROWS*COLS)  row*COLS + col
key_repeat  out  1  the held event is an auto-repeat
key_down  out  1  a confirmed key is currently held
multi_key  out  1  one-clk pulse: more than one row was seen in the scanned column
overflow  out  1  sticky: an event was dropped

Behaviour:
Reset (reset=0, asynchronous):
- State SCAN, col_idx=0, col_drive=1 (bit 0 only).
- key_valid, key_code, key_repeat, key_down, multi_key, overflow all 0.
- Synchroniser flops and all counters 0.

General rules:
- rows_in passes through a 2-flop synchroniser to give rows_s, a 2-clk latency.
- All state and counter updates happen only on clk edges where tick=1, except the output handshake and clr_overflow, which act every clk.
- col_drive is always the one-hot encoding of col_idx.

FSM:
- SCAN
  - On tick, popcount(rows_s)==0: col_idx advances, wrapping COLS-1 -> 0.
  - On tick, popcount(rows_s)>1: multi_key pulses for one clk, col_idx advances, no capture.
  - On tick, popcount(rows_s)==1: capture row_idx and col_idx, db_cnt=0, go to DEBOUNCE. col_idx is frozen.
- DEBOUNCE
  - On tick, rows_s equals the captured one-hot row: db_cnt++.
    - When db_cnt+1 == DEBOUNCE_TICKS: emit a press event (key_repeat=0), go to PRESSED, rpt_cnt=0, first_done=0.
  - On tick, any mismatch: return to SCAN with col_idx advanced, no event.
- PRESSED
  - key_down=1.
  - On tick, captured row bit is 0: go to RELEASE_DB, db_cnt=0.
  - Otherwise, if repeat_en=1: rpt_cnt++.
    - Limit is REPEAT_DELAY when first_done=0, REPEAT_RATE when first_done=1.
    - When rpt_cnt+1 == limit: emit a repeat event (key_repeat=1), rpt_cnt=0, first_done=1.
  - repeat_en=0 holds rpt_cnt=0 and first_done=0.
- RELEASE_DB
  - key_down=1.
  - On tick, row bit is 0: db_cnt++. When db_cnt+1 == DEBOUNCE_TICKS: go to SCAN, col_idx advances.
  - On tick, row bit is 1: return to PRESSED. rpt_cnt and first_done are retained.
- Any illegal state goes to SCAN.

Output register and handshake:
- An event loads key_code = row_idx*COLS + col_idx and key_repeat at the same edge as the state transition. key_valid is 1 from the next cycle.
- Load is allowed if key_valid=0, or key_valid=1 with key_ready=1 in that cycle (same-cycle consume and refill).
- key_valid=1 with key_ready=0 at the event: the event is dropped, overflow is set to 1 and the held data is unchanged.
- key_valid=1 with key_ready=1 and no event: key_valid goes to 0 and key_code holds its value.
- clr_overflow=1 clears overflow. If a drop occurs in the same cycle, the set wins.
- Counter widths are $clog2(max+1). Codes are computed in CW bits and never wrap.
- A reset mid-operation aborts immediately and no pending event is emitted.

Test Plan:
1. tick every clk, no keys -> col_drive cycles 1,2,4,8,1; key_valid stays 0; after 4 ticks col_drive returns to 1.
2. Hold row 2 on column 1 for 10 ticks, key_ready=1 -> exactly one event, key_code=9, key_repeat=0; key_down=1; no further events with repeat_en=0.
3. Row 2 asserted for 2 ticks, then released (bounce) -> no event; scanning resumes at column 2.
4. repeat_en=1, hold key 9 for 60 ticks after the press confirms -> repeat events at held ticks 32, 40, 48, 56, each with key_code=9, key_repeat=1.
5. key_ready=0, press key 9 then key 6 -> key_code stays 9, overflow=1; a clr_overflow pulse clears it; key_ready=1 then gives key_valid=0.
6. Rows 0 and 3 both asserted on column 0 -> multi_key pulses and no capture. Separately, assert reset mid-DEBOUNCE -> all outputs 0 and col_drive=1 immediately.
